// File: rtl/ibex_register_file_mp.sv
// ibex_register_file_mp
//   Flop-based multi-ported integer register file with optional same-cycle
//   write forwarding, optional dummy-instruction shadow r0, and a sequenced
//   scrub engine that zeroes every word without asserting reset.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   test_en_i           unused
//   dummy_instr_id_i    selects the shadow r0 for reads/writes of address 0
//   raddr_i / rdata_o   packed read ports (5-bit address, DataWidth data each)
//   waddr_i / wdata_i   packed write ports, we_i per-port enables
//                       (port 1 overrides port 0 on an address clash)
//   clear_req_i         one-cycle scrub request (honoured only when idle)
//   clear_busy_o        scrub in progress; writes are ignored meanwhile
//   clear_done_o        one-cycle pulse when the scrub completes
//   perr_o              sticky parity error flag
//
// Configuration
//   IBEX_RF_PARITY_EN   when defined, every word carries an even-parity bit and
//                       perr_o flags a mismatch on any read port one cycle after
//                       the read. When undefined, perr_o is tied to 0.
module ibex_register_file_mp #(
  parameter bit          RV32E             = 1'b0,
  parameter int unsigned DataWidth         = 32,
  parameter int unsigned NumReadPorts      = 2,
  parameter int unsigned NumWritePorts     = 2,
  parameter bit          WriteForward      = 1'b0,
  parameter bit          DummyInstructions = 1'b0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              test_en_i,
  input  logic                              dummy_instr_id_i,
  input  logic [NumReadPorts*5-1:0]         raddr_i,
  output logic [NumReadPorts*DataWidth-1:0] rdata_o,
  input  logic [NumWritePorts*5-1:0]        waddr_i,
  input  logic [NumWritePorts*DataWidth-1:0] wdata_i,
  input  logic [NumWritePorts-1:0]          we_i,
  input  logic                              clear_req_i,
  output logic                              clear_busy_o,
  output logic                              clear_done_o,
  output logic                              perr_o
);

  // state | meaning
  // IDLE  | normal operation, waiting for clear_req_i
  // CLEAR | zeroing word[ptr] each cycle, ptr = 1 .. NumWords-1
  // DONE  | scrub finished, clear_done_o pulses for this one cycle

  localparam int unsigned NumWords = RV32E ? 16 : 32;
  localparam int unsigned AddrW    = RV32E ? 4 : 5;
  localparam logic [4:0]  LastPtr  = 5'(NumWords - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;

  state_e                 state_q, state_d;
  logic [4:0]             ptr_q, ptr_d;
  logic [DataWidth-1:0]   mem_q [NumWords];
  logic [DataWidth-1:0]   mem_d [NumWords];
  logic [DataWidth-1:0]   shadow_q;
  logic [4:0]             waddr [NumWritePorts];
  logic [DataWidth-1:0]   wdata [NumWritePorts];
  logic [NumWritePorts-1:0] wr_valid;
  logic                   dummy_en;
  logic                   shadow_we;
  logic [DataWidth-1:0]   shadow_wdata;
  logic                   unused_test_en;

  assign unused_test_en = test_en_i;
  assign dummy_en       = DummyInstructions && dummy_instr_id_i;

  function automatic logic addr_legal(input logic [4:0] a);
    return !(RV32E && a[4]);
  endfunction

  // Scrub FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Scrub FSM: next state
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clear_req_i) begin
          state_d = CLEAR;
          ptr_d   = 5'd1;
        end
      end
      CLEAR: begin
        if (ptr_q == LastPtr) state_d = DONE;
        else                  ptr_d   = ptr_q + 5'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scrub FSM: outputs
  always_comb begin
    clear_busy_o = (state_q == CLEAR);
    clear_done_o = (state_q == DONE);
  end

  // Write port decode; writes are suppressed entirely while scrubbing.
  always_comb begin
    wr_valid     = '0;
    shadow_we    = 1'b0;
    shadow_wdata = '0;
    for (int w = 0; w < NumWritePorts; w++) begin
      waddr[w] = waddr_i[w*5 +: 5];
      wdata[w] = wdata_i[w*DataWidth +: DataWidth];
      wr_valid[w] = we_i[w] && !clear_busy_o && (waddr[w] != 5'd0) && addr_legal(waddr[w]);
      // Ascending loop order lets port 1 override port 0.
      if (we_i[w] && !clear_busy_o && dummy_en && (waddr[w] == 5'd0)) begin
        shadow_we    = 1'b1;
        shadow_wdata = wdata[w];
      end
    end
  end

`ifdef IBEX_RF_PARITY_EN
  logic [NumWords-1:0]     par_q, par_d;
  logic [NumReadPorts-1:0] mism;
  logic                    perr_q;
`endif

  always_comb begin
    mem_d = mem_q;
`ifdef IBEX_RF_PARITY_EN
    par_d = par_q;
`endif
    for (int w = 0; w < NumWritePorts; w++) begin
      if (wr_valid[w]) begin
        mem_d[waddr[w][AddrW-1:0]] = wdata[w];
`ifdef IBEX_RF_PARITY_EN
        par_d[waddr[w][AddrW-1:0]] = ^wdata[w];
`endif
      end
    end
    if (state_q == CLEAR) begin
      mem_d[ptr_q[AddrW-1:0]] = '0;
`ifdef IBEX_RF_PARITY_EN
      par_d[ptr_q[AddrW-1:0]] = 1'b0;
`endif
    end
  end

  // Word 0 is never selected by a write or the scrub, so it stays zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumWords; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                 shadow_q <= '0;
    else if (state_q == CLEAR && ptr_q == 5'd1)  shadow_q <= '0;
    else if (shadow_we)                          shadow_q <= shadow_wdata;
  end

  // Read ports: combinational, optionally forwarding same-cycle write data.
  always_comb begin
    logic [4:0]           a;
    logic [DataWidth-1:0] rd;
    logic                 fwd;
    rdata_o = '0;
`ifdef IBEX_RF_PARITY_EN
    mism = '0;
`endif
    for (int p = 0; p < NumReadPorts; p++) begin
      a   = raddr_i[p*5 +: 5];
      rd  = '0;
      fwd = 1'b0;
      if (a == 5'd0)          rd = dummy_en ? shadow_q : '0;
      else if (addr_legal(a)) rd = mem_q[a[AddrW-1:0]];
      if (WriteForward) begin
        for (int w = 0; w < NumWritePorts; w++) begin
          if (wr_valid[w] && waddr[w] == a) begin
            rd  = wdata[w];
            fwd = 1'b1;
          end
        end
      end
`ifdef IBEX_RF_PARITY_EN
      mism[p] = (a != 5'd0) && addr_legal(a) && !fwd &&
                ((^mem_q[a[AddrW-1:0]]) != par_q[a[AddrW-1:0]]);
`endif
      rdata_o[p*DataWidth +: DataWidth] = rd;
    end
  end

`ifdef IBEX_RF_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_q  <= '0;
      perr_q <= 1'b0;
    end else begin
      par_q <= par_d;
      if (state_q == DONE) perr_q <= 1'b0;
      else                 perr_q <= perr_q | (|mism);
    end
  end
  assign perr_o = perr_q;
`else
  assign perr_o = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_register_file_mp.sv
module tb_ibex_register_file_mp;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  // Instance A: 32 words, no forwarding, no shadow r0.
  logic [9:0]  raddr_a = '0, waddr_a = '0;
  logic [63:0] rdata_a, wdata_a = '0;
  logic [1:0]  we_a = '0;
  logic        clr_a = 1'b0, busy_a, done_a, perr_a;
  // Instance B: RV32E, forwarding, shadow r0.
  logic [9:0]  raddr_b = '0, waddr_b = '0;
  logic [63:0] rdata_b, wdata_b = '0;
  logic [1:0]  we_b = '0;
  logic        clr_b = 1'b0, busy_b, done_b, perr_b, dummy_b = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_a [32];
  int busy_cnt, done_cnt;

  ibex_register_file_mp #(.RV32E(1'b0), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(2),
                          .WriteForward(1'b0), .DummyInstructions(1'b0)) dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_en_i(1'b0), .dummy_instr_id_i(1'b0),
    .raddr_i(raddr_a), .rdata_o(rdata_a), .waddr_i(waddr_a), .wdata_i(wdata_a), .we_i(we_a),
    .clear_req_i(clr_a), .clear_busy_o(busy_a), .clear_done_o(done_a), .perr_o(perr_a));

  ibex_register_file_mp #(.RV32E(1'b1), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(2),
                          .WriteForward(1'b1), .DummyInstructions(1'b1)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_en_i(1'b0), .dummy_instr_id_i(dummy_b),
    .raddr_i(raddr_b), .rdata_o(rdata_b), .waddr_i(waddr_b), .wdata_i(wdata_b), .we_i(we_b),
    .clear_req_i(clr_b), .clear_busy_o(busy_b), .clear_done_o(done_b), .perr_o(perr_b));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk_i);
    we_a = '0; we_b = '0; clr_a = 1'b0; clr_b = 1'b0;
  endtask

  task automatic wr_a(input int p, input logic [4:0] a, input logic [31:0] d);
    waddr_a[p*5 +: 5] = a; wdata_a[p*32 +: 32] = d; we_a[p] = 1'b1;
  endtask

  task automatic wr_b(input int p, input logic [4:0] a, input logic [31:0] d);
    waddr_b[p*5 +: 5] = a; wdata_b[p*32 +: 32] = d; we_b[p] = 1'b1;
  endtask

  // Scoreboard reads: the expectation is queued as the address is driven,
  // then popped and compared once the combinational read has settled.
  task automatic rd_a(input int p, input logic [4:0] a, input logic [31:0] exp, input string tag);
    raddr_a[p*5 +: 5] = a;
    exp_q.push_back(exp);
    #1;
    check_val(tag, rdata_a[p*32 +: 32], exp_q.pop_front());
  endtask

  task automatic rd_b(input int p, input logic [4:0] a, input logic [31:0] exp, input string tag);
    raddr_b[p*5 +: 5] = a;
    exp_q.push_back(exp);
    #1;
    check_val(tag, rdata_b[p*32 +: 32], exp_q.pop_front());
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_a[i] = '0;

    // Reset state
    repeat (2) nxt();
    check_val("rst_busy", {31'd0, busy_a}, 32'd0);
    check_val("rst_done", {31'd0, done_a}, 32'd0);
    check_val("rst_perr", {31'd0, perr_a}, 32'd0);
    rd_a(0, 5'd5, 32'h0, "rst_rd5");
    rd_b(0, 5'd3, 32'h0, "rst_rd_b");

    // Basic write, no forwarding on A
    nxt(); rst_ni = 1'b1;
    wr_a(0, 5'd5, 32'hDEADBEEF);
    rd_a(0, 5'd5, 32'h0, "nofwd_5");
    nxt();
    rd_a(0, 5'd5, 32'hDEADBEEF, "wr_rd5");
    rd_a(1, 5'd0, 32'h0, "rd0");

    // Port 1 priority, r0 write dropped
    wr_a(0, 5'd7, 32'h11); wr_a(1, 5'd7, 32'h22);
    nxt(); wr_a(0, 5'd0, 32'hFF);
    nxt();
    rd_a(0, 5'd7, 32'h22, "wprio_7");
    rd_a(1, 5'd0, 32'h0, "r0_drop");

    // WriteForward=0 returns pre-edge value
    wr_a(0, 5'd9, 32'h1234);
    nxt(); wr_a(0, 5'd9, 32'hA5A5);
    rd_a(0, 5'd9, 32'h1234, "nofwd_9");
    nxt();
    rd_a(0, 5'd9, 32'hA5A5, "commit_9");

    // Fill every word, then read all back
    for (int i = 1; i < 32; i += 2) begin
      nxt();
      m_a[i] = 32'h1000_0000 | i;
      wr_a(0, 5'(i), m_a[i]);
      if (i + 1 < 32) begin
        m_a[i+1] = 32'h2000_0000 | (i + 1);
        wr_a(1, 5'(i + 1), m_a[i+1]);
      end
    end
    for (int i = 0; i < 32; i += 2) begin
      nxt();
      rd_a(0, 5'(i), m_a[i], "fill_rd_p0");
      rd_a(1, 5'(i + 1), m_a[i+1], "fill_rd_p1");
    end

    // Scrub with a same-cycle write in IDLE, ignored writes/requests after
    nxt(); clr_a = 1'b1; wr_a(0, 5'd6, 32'h66);
    nxt();
    check_val("busy_rise", {31'd0, busy_a}, 32'd1);
    rd_a(0, 5'd6, 32'h66, "partial_rd6");
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      if (c > 0) nxt();
      if (busy_a) busy_cnt++;
      if (done_a) begin done_cnt++; clr_a = 1'b1; end
      if (c == 3) clr_a = 1'b1;
      if (c == 8) wr_a(0, 5'd2, 32'hBAD);
    end
    check_val("scrub_busy_cnt", busy_cnt, 32'd31);
    check_val("scrub_done_cnt", done_cnt, 32'd1);
    for (int i = 0; i < 32; i += 2) begin
      nxt();
      rd_a(0, 5'(i), 32'h0, "scrub_rd_p0");
      rd_a(1, 5'(i + 1), 32'h0, "scrub_rd_p1");
    end

    // Reset in the middle of a scrub
    nxt(); wr_a(0, 5'd30, 32'h30);
    nxt(); clr_a = 1'b1;
    repeat (5) nxt();
    check_val("busy_mid", {31'd0, busy_a}, 32'd1);
    rd_a(0, 5'd30, 32'h30, "mid_rd30");
    rst_ni = 1'b0; #1;
    check_val("rst_mid_busy", {31'd0, busy_a}, 32'd0);
    check_val("rst_mid_done", {31'd0, done_a}, 32'd0);
    rd_a(0, 5'd30, 32'h0, "rst_mid_rd30");
    nxt(); rst_ni = 1'b1;
    done_cnt = 0;
    repeat (40) begin nxt(); if (done_a || busy_a) done_cnt++; end
    check_val("rst_mid_quiet", done_cnt, 32'd0);

    // Instance B: RV32E aliasing
    nxt(); wr_b(0, 5'd20, 32'h5);
    nxt();
    rd_b(0, 5'd20, 32'h0, "e_rd20");
    rd_b(1, 5'd4, 32'h0, "e_rd4");

    // Forwarding
    wr_b(0, 5'd9, 32'h1234);
    nxt(); wr_b(0, 5'd9, 32'hA5A5);
    rd_b(0, 5'd9, 32'hA5A5, "fwd_9");
    nxt(); wr_b(0, 5'd10, 32'h1); wr_b(1, 5'd10, 32'h2);
    rd_b(1, 5'd10, 32'h2, "fwd_prio");
    rd_b(0, 5'd9, 32'hA5A5, "fwd_commit9");
    nxt();
    rd_b(0, 5'd10, 32'h2, "wprio_b");

    // Shadow r0
    dummy_b = 1'b1; wr_b(0, 5'd0, 32'hD0);
    rd_b(0, 5'd0, 32'h0, "shadow_nofwd");
    nxt();
    rd_b(0, 5'd0, 32'hD0, "shadow_rd");
    dummy_b = 1'b0;
    rd_b(1, 5'd0, 32'h0, "shadow_hidden");

    // Scrub on 16 words
    nxt(); clr_b = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      nxt();
      if (busy_b) busy_cnt++;
      if (done_b) done_cnt++;
    end
    check_val("e_busy_cnt", busy_cnt, 32'd15);
    check_val("e_done_cnt", done_cnt, 32'd1);
    rd_b(0, 5'd9, 32'h0, "e_scrub_rd9");
    dummy_b = 1'b1;
    rd_b(1, 5'd0, 32'h0, "e_scrub_shadow");
    dummy_b = 1'b0;
    check_val("no_perr_b", {31'd0, perr_b}, 32'd0);

`ifdef IBEX_RF_PARITY_EN
    nxt(); wr_a(0, 5'd3, 32'h3);
    nxt();
    dut_a.mem_q[3] = dut_a.mem_q[3] ^ 32'h1;
    check_val("perr_pre", {31'd0, perr_a}, 32'd0);
    rd_a(0, 5'd3, 32'h2, "flip_rd3");
    nxt(); raddr_a = '0; #1;
    check_val("perr_set", {31'd0, perr_a}, 32'd1);
    repeat (3) nxt();
    check_val("perr_sticky", {31'd0, perr_a}, 32'd1);
    clr_a = 1'b1;
    repeat (40) nxt();
    check_val("perr_clr", {31'd0, perr_a}, 32'd0);
`else
    check_val("perr_off", {31'd0, perr_a}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
